// File: rtl/ofdm_pkg.sv
// Shared OFDM receiver definitions: default symbol geometry, sample width and
// the cyclic-prefix remover FSM encoding.
package ofdm_pkg;

  localparam int unsigned NFFT_DEF = 256;
  localparam int unsigned NCP_DEF  = 64;
  localparam int unsigned SAMPLE_W = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } cp_state_e;

endpackage

// File: rtl/cp_fifo.sv
// Synchronous show-ahead FIFO: rdata_o always presents the head entry while not empty.
// Depth is 2**AddrW; pushes while full and pops while empty are ignored.
module cp_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned AddrW = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned Depth = 2 ** AddrW;
  localparam logic [AddrW:0] PtrOne = {{AddrW{1'b0}}, 1'b1};

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/cp_remove.sv
// Cyclic-prefix remover: drops the first NCP samples of each symbol and forwards the
// NFFT useful samples through a skid FIFO. Optional SOF_O flag under CP_REMOVE_SOF_EN.
module cp_remove
  import ofdm_pkg::*;
#(
  parameter int unsigned NFFT    = NFFT_DEF,
  parameter int unsigned NCP     = NCP_DEF,
  parameter int unsigned FIFO_AW = 3
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic [SAMPLE_W-1:0] DAT_I,
  input  logic                CYC_I,
  input  logic                STB_I,
  output logic                ACK_O,
  output logic [SAMPLE_W-1:0] DAT_O,
  output logic                CYC_O,
  output logic                STB_O,
  output logic                WE_O,
`ifdef CP_REMOVE_SOF_EN
  output logic                SOF_O,
`endif
  input  logic                ACK_I
);

  localparam int unsigned CntW = $clog2(NCP + NFFT);
  localparam logic [CntW-1:0] NcpC   = CntW'(NCP);
  localparam logic [CntW-1:0] LastC  = CntW'(NCP + NFFT - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
`ifdef CP_REMOVE_SOF_EN
  localparam int unsigned FifoW = SAMPLE_W + 1;
`else
  localparam int unsigned FifoW = SAMPLE_W;
`endif

  cp_state_e       state_q, state_d;
  logic [CntW-1:0] smp_cnt_q, smp_cnt_d;
  logic [15:0]     sym_cnt_q, sym_cnt_d;
  logic            cyc_q, cyc_d;

  logic             in_cp, ack, push, pop;
  logic             fifo_full, fifo_empty;
  logic [FifoW-1:0] fifo_wdata, fifo_rdata;

  always_comb begin
    state_d   = state_q;
    smp_cnt_d = smp_cnt_q;
    sym_cnt_d = sym_cnt_q;
    cyc_d     = cyc_q;
    in_cp     = (smp_cnt_q < NcpC);
    ack       = 1'b0;
    push      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (CYC_I) begin
          state_d   = StRun;
          smp_cnt_d = '0;
          sym_cnt_d = '0;
        end
      end
      StRun: begin
        ack  = CYC_I & STB_I & (in_cp | ~fifo_full);
        push = ack & ~in_cp;
        if (ack) begin
          if (smp_cnt_q == LastC) begin
            smp_cnt_d = '0;
            sym_cnt_d = sym_cnt_q + 16'd1;
          end else begin
            smp_cnt_d = smp_cnt_q + CntOne;
          end
        end
        if (push) cyc_d = 1'b1;
        if (!CYC_I) state_d = StDrain;
      end
      StDrain: begin
        if (fifo_empty) begin
          state_d = StIdle;
          cyc_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q   <= StIdle;
      smp_cnt_q <= '0;
      sym_cnt_q <= '0;
      cyc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      smp_cnt_q <= smp_cnt_d;
      sym_cnt_q <= sym_cnt_d;
      cyc_q     <= cyc_d;
    end
  end

  // The symbol count may only advance when the sample counter wraps.
  always_ff @(posedge CLK_I) begin
    if (!RST_I && state_q == StRun && sym_cnt_d != sym_cnt_q) begin
      assert (smp_cnt_q == LastC);
    end
  end

`ifdef CP_REMOVE_SOF_EN
  assign fifo_wdata = {(smp_cnt_q == NcpC), DAT_I};
  assign SOF_O      = ~fifo_empty & fifo_rdata[SAMPLE_W];
`else
  assign fifo_wdata = DAT_I;
`endif

  assign pop = ~fifo_empty & ACK_I;

  cp_fifo #(
    .Width (FifoW),
    .AddrW (FIFO_AW)
  ) u_fifo (
    .clk_i   (CLK_I),
    .rst_i   (RST_I),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign ACK_O = ack;
  assign STB_O = ~fifo_empty;
  assign DAT_O = fifo_empty ? '0 : fifo_rdata[SAMPLE_W-1:0];
  assign CYC_O = cyc_q;
  assign WE_O  = cyc_q;

endmodule

// File: tb/tb_cp_remove.sv
// Scoreboard bench for cp_remove: the driver queues expected useful samples as they are
// accepted, and a monitor pops and compares on every output handshake.
module tb_cp_remove;

  localparam int Bound = 2000;

  logic        clk = 1'b0;
  logic        RST_I, CYC_I, STB_I, ACK_I;
  logic [31:0] DAT_I;
  logic        ACK_O, CYC_O, STB_O, WE_O;
  logic [31:0] DAT_O;
`ifdef CP_REMOVE_SOF_EN
  logic        SOF_O;
`endif

  int checks  = 0;
  int errors  = 0;
  int out_cnt = 0;
  int acc_cnt = 0;
  bit cyc_seen = 1'b0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  cp_remove dut (
    .CLK_I (clk),
    .RST_I (RST_I),
    .DAT_I (DAT_I),
    .CYC_I (CYC_I),
    .STB_I (STB_I),
    .ACK_O (ACK_O),
    .DAT_O (DAT_O),
    .CYC_O (CYC_O),
    .STB_O (STB_O),
    .WE_O  (WE_O),
`ifdef CP_REMOVE_SOF_EN
    .SOF_O (SOF_O),
`endif
    .ACK_I (ACK_I)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every output handshake against the scoreboard head.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_dat   = '0;
  always @(negedge clk) begin
    logic [32:0] e;
    if (CYC_O) cyc_seen = 1'b1;
    if (prev_stall && STB_O) check("dat_o_stable", DAT_O, prev_dat);
    if (STB_O && ACK_I && !RST_I) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got 0x%0h, expected no output", DAT_O);
      end else begin
        e = exp_q.pop_front();
        check("dat_o", DAT_O, e[31:0]);
        check("we_o_eq_cyc_o", {31'd0, WE_O}, {31'd0, CYC_O});
`ifdef CP_REMOVE_SOF_EN
        check("sof_o", {31'd0, SOF_O}, {31'd0, e[32]});
`endif
      end
    end
    prev_stall = STB_O & ~ACK_I;
    prev_dat   = DAT_O;
  end

  // Drive n samples with DAT_I = index; useful ones (index mod 320 >= 64) are expected.
  task automatic send_samples(input int n);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      CYC_I = 1'b1;
      STB_I = 1'b1;
      DAT_I = 32'(i);
      @(negedge clk);
      while (!ACK_O && guard < Bound) begin
        @(negedge clk);
        guard++;
      end
      if (!ACK_O) begin
        checks++;
        errors++;
        $display("FAIL ack_timeout: sample %0d not accepted, required ACK_O=1", i);
        break;
      end
      if ((i % 320) >= 64) exp_q.push_back({((i % 320) == 64), 32'(i)});
      acc_cnt++;
      @(posedge clk);
      #1;
    end
    STB_I = 1'b0;
  endtask

  task automatic end_frame();
    int guard = 0;
    CYC_I = 1'b0;
    STB_I = 1'b0;
    @(negedge clk);
    while ((CYC_O || STB_O) && guard < Bound) begin
      @(negedge clk);
      guard++;
    end
    check("drain_done", {30'd0, CYC_O, STB_O}, 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    RST_I = 1'b1;
    CYC_I = 1'b0;
    STB_I = 1'b0;
    DAT_I = '0;
    ACK_I = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {27'd0, STB_O, CYC_O, WE_O, ACK_O, 1'b0}, 32'd0);
    check("reset_dat_o", DAT_O, 32'd0);
    @(posedge clk);
    #1 RST_I = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single symbol, free-flowing output.
    base = out_cnt;
    cyc_seen = 1'b0;
    send_samples(320);
    check("cyc_o_raised", {31'd0, cyc_seen}, 32'd1);
    end_frame();
    check("one_symbol_outputs", 32'(out_cnt - base), 32'd256);

    // Three back-to-back symbols.
    base = out_cnt;
    send_samples(960);
    end_frame();
    check("three_symbol_outputs", 32'(out_cnt - base), 32'd768);

    // Back-pressure: FIFO fills with 8 entries and stalls input.
    base = out_cnt;
    acc_cnt = 0;
    ACK_I = 1'b0;
    fork
      send_samples(320);
      begin
        int guard = 0;
        while (acc_cnt < 72 && guard < Bound) begin
          @(negedge clk);
          guard++;
        end
        repeat (10) @(negedge clk);
        check("bp_accepted", 32'(acc_cnt), 32'd72);
        check("bp_ack_o_low", {31'd0, ACK_O}, 32'd0);
        check("bp_stb_o_high", {31'd0, STB_O}, 32'd1);
        check("bp_dat_o_head", DAT_O, 32'd64);
        @(posedge clk);
        #1 ACK_I = 1'b1;
      end
    join
    end_frame();
    check("bp_outputs", 32'(out_cnt - base), 32'd256);

    // Frame truncated mid-symbol, then a fresh full frame.
    base = out_cnt;
    send_samples(100);
    end_frame();
    check("partial_outputs", 32'(out_cnt - base), 32'd36);
    base = out_cnt;
    send_samples(320);
    end_frame();
    check("after_partial_outputs", 32'(out_cnt - base), 32'd256);

    // CP-only frame never raises CYC_O.
    base = out_cnt;
    cyc_seen = 1'b0;
    send_samples(64);
    end_frame();
    check("cp_only_no_cyc", {31'd0, cyc_seen}, 32'd0);
    check("cp_only_outputs", 32'(out_cnt - base), 32'd0);

    // Reset with 5 entries buffered.
    ACK_I = 1'b0;
    send_samples(69);
    @(negedge clk);
    check("pre_reset_stb", {31'd0, STB_O}, 32'd1);
    @(posedge clk);
    #1 RST_I = 1'b1;
    @(posedge clk);
    #1 RST_I = 1'b0;
    STB_I = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", {29'd0, STB_O, CYC_O, ACK_O}, 32'd0);
    exp_q.delete();
    CYC_I = 1'b0;
    STB_I = 1'b0;
    ACK_I = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    base = out_cnt;
    send_samples(320);
    end_frame();
    check("post_reset_outputs_cnt", 32'(out_cnt - base), 32'd256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
